// File: rtl/mult_unit.sv
// mult_unit -- iterative RV32M-style integer multiplier for the execute stage.
//
// Computes MUL / MULH / MULHSU / MULHU by accumulating BITS_PER_CYCLE
// multiplier bits per BUSY cycle into a 2*XLEN accumulator. After
// N = 2*XLEN/BITS_PER_CYCLE iterations the unit spends one cycle in DONE
// with a registered result pulse. A tag travels with each operation.
//
// Optional feature: define MULT_ZERO_BYPASS_EN to finish an operation with a
// zero operand one cycle after acceptance instead of iterating.
//
// Handshake: a request is taken on a rising edge where start=1 and ready=1.
// ready is high in IDLE or DONE while squash is low. done is a single-cycle
// pulse, and product/tag_out are valid with it and hold until the next done.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request (taken only when ready=1)
//   func     in   2'b00 MUL, 2'b01 MULH, 2'b10 MULHSU, 2'b11 MULHU
//   mcand    in   rs1 operand (XLEN)
//   mplier   in   rs2 operand (XLEN)
//   tag_in   in   tag captured with the request (TAG_W)
//   squash   in   abort any in-flight operation, block acceptance
//   ready    out  unit can accept start this cycle (combinational)
//   done     out  one-cycle result-valid pulse (registered)
//   product  out  result (registered, XLEN)
//   tag_out  out  tag of the result (registered, TAG_W)
//   state_o  out  current FSM state, for debug and checkers

module mult_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 8,
  parameter int TAG_W          = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       func,
  input  logic [XLEN-1:0]  mcand,
  input  logic [XLEN-1:0]  mplier,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             squash,
  output logic             ready,
  output logic             done,
  output logic [XLEN-1:0]  product,
  output logic [TAG_W-1:0] tag_out,
  output logic [1:0]       state_o
);

  localparam int W2    = 2 * XLEN;
  localparam int N     = W2 / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;    // extended multiplicand, shifted left each iteration
  logic [W2-1:0]    mplier_q, mplier_d;  // extended multiplier, shifted right each iteration
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hi_q, hi_d;          // 1: return upper half of the accumulator
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  product_q, product_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;

  logic             accept;
  logic             zero_op;
  logic [W2-1:0]    mcand_ext;
  logic [W2-1:0]    mplier_ext;
  logic [W2-1:0]    chunk_ext;
  logic [W2-1:0]    partial;
  logic [W2-1:0]    acc_sum;

  assign ready   = ((state_q == S_IDLE) || (state_q == S_DONE)) && !squash;
  assign accept  = start && ready;
  assign done    = done_q;
  assign product = product_q;
  assign tag_out = tag_out_q;
  assign state_o = state_q;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (mcand == '0) || (mplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  // mcand is signed for MUL/MULH/MULHSU; mplier is signed only for MUL/MULH.
  // With both operands extended to 2*XLEN, the low 2*XLEN bits of their
  // unsigned product equal the correctly signed product.
  assign mcand_ext  = {{XLEN{mcand[XLEN-1] & (func != 2'b11)}}, mcand};
  assign mplier_ext = {{XLEN{mplier[XLEN-1] & ~func[1]}}, mplier};

  always_comb begin
    chunk_ext = '0;
    chunk_ext[BITS_PER_CYCLE-1:0] = mplier_q[BITS_PER_CYCLE-1:0];
  end

  assign partial = mcand_q * chunk_ext;
  assign acc_sum = acc_q + partial;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    tag_d     = tag_q;
    done_d    = 1'b0;
    product_d = product_q;
    tag_out_d = tag_out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = mcand_ext;
          mplier_d = mplier_ext;
          hi_d     = (func != 2'b00);
          tag_d    = tag_in;
          if (zero_op) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            product_d = '0;
            tag_out_d = tag_in;
          end else begin
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (squash) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            product_d = hi_q ? acc_sum[W2-1:XLEN] : acc_sum[XLEN-1:0];
            tag_out_d = tag_q;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      hi_q      <= 1'b0;
      tag_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      tag_q     <= tag_d;
      done_q    <= done_d;
      product_q <= product_d;
      tag_out_q <= tag_out_d;
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Testbench for mult_unit: directed RV32M cases, back-to-back issue, squash,
// reset mid-operation, zero operands and a random run against a signed
// reference model. Results and latencies are matched through a scoreboard.

module tb_mult_unit;

  localparam int XLEN  = 32;
  localparam int BPC   = 8;
  localparam int TAG_W = 6;
  localparam int N     = 2 * XLEN / BPC;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [1:0]       func;
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [TAG_W-1:0] tag_in;
  logic             squash;
  logic             ready;
  logic             done;
  logic [XLEN-1:0]  product;
  logic [TAG_W-1:0] tag_out;
  logic [1:0]       state_o;

  mult_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .TAG_W(TAG_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .func    (func),
    .mcand   (mcand),
    .mplier  (mplier),
    .tag_in  (tag_in),
    .squash  (squash),
    .ready   (ready),
    .done    (done),
    .product (product),
    .tag_out (tag_out),
    .state_o (state_o)
  );

  // ---------------- clock / cycle counter ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] tag_q[$];
  int               e0_q[$];
  int               lat_q[$];

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [XLEN-1:0]  last_prod = '0;
  logic [TAG_W-1:0] last_tag  = '0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  // Reference: operands widened by one bit with the right signedness,
  // multiplied as signed numbers, then the requested half selected.
  function automatic logic [XLEN-1:0] model(input logic [1:0] f,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [XLEN:0]     sa;
    logic signed [XLEN:0]     sb;
    logic signed [2*XLEN+1:0] p;
    sa = {(f != 2'b11) ? a[XLEN-1] : 1'b0, a};
    sb = {(f[1] == 1'b0) ? b[XLEN-1] : 1'b0, b};
    p  = sa * sb;
    return (f == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic int lat_for(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef MULT_ZERO_BYPASS_EN
    return ((a == '0) || (b == '0)) ? 1 : N;
`else
    return N;
`endif
  endfunction

  // Result monitor: samples 1 time unit after every rising edge.
  always @(posedge clock) begin
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        logic [XLEN-1:0]  ep;
        logic [TAG_W-1:0] et;
        int               e0;
        int               el;
        ep = exp_q.pop_front();
        et = tag_q.pop_front();
        e0 = e0_q.pop_front();
        el = lat_q.pop_front();
        chk("product", 64'(product), 64'(ep));
        chk("tag_out", 64'(tag_out), 64'(et));
        chk("latency", 64'(cyc - e0), 64'(el));
        last_prod = ep;
        last_tag  = et;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns 1 time unit after the accept edge.
  task automatic issue(input logic [1:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t,
                       input bit expect_done);
    func   = f;
    mcand  = a;
    mplier = b;
    tag_in = t;
    start  = 1'b1;
    #1;
    chk("ready_at_issue", 64'(ready), 64'(1));
    @(posedge clock);
    #1;
    start  = 1'b0;
    // Scramble inputs after acceptance; they must not affect the result.
    func   = 2'($urandom_range(0, 3));
    mcand  = XLEN'({$urandom(), $urandom()});
    mplier = XLEN'({$urandom(), $urandom()});
    tag_in = TAG_W'($urandom());
    if (expect_done) begin
      exp_q.push_back(model(f, a, b));
      tag_q.push_back(t);
      e0_q.push_back(cyc);
      lat_q.push_back(lat_for(a, b));
    end
  endtask

  // Wait until every expected result was seen; returns on a falling edge.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
    @(negedge clock);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int d0;
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    squash  = 1'b0;
    func    = 2'b00;
    mcand   = '0;
    mplier  = '0;
    tag_in  = '0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_product", 64'(product), 64'(0));
    chk("rst_tag_out", 64'(tag_out), 64'(0));
    chk("rst_state", 64'(state_o), 64'(0));
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", 64'(ready), 64'(1));

    // Basic ops
    issue(2'b00, XLEN'(2), XLEN'(3), TAG_W'(1), 1'b1);       drain(N + 5);
    issue(2'b00, XLEN'(5), XLEN'(50), TAG_W'(2), 1'b1);      drain(N + 5);
    chk("mul_5x50", 64'(product), 64'(32'h0000_00FA));
    issue(2'b11, '1, '1, TAG_W'(3), 1'b1);                   drain(N + 5);
    chk("mulhu_ones", 64'(product), 64'(32'hFFFF_FFFE));
    issue(2'b01, '1, '1, TAG_W'(4), 1'b1);                   drain(N + 5);
    chk("mulh_ones", 64'(product), 64'(32'h0000_0000));
    issue(2'b10, '1, '1, TAG_W'(5), 1'b1);                   drain(N + 5);
    chk("mulhsu_ones", 64'(product), 64'(32'hFFFF_FFFF));

    // Back-to-back: second start issued in the DONE cycle
    issue(2'b00, XLEN'(7), XLEN'(9), TAG_W'(6), 1'b1);
    n = 0;
    while (done !== 1'b1 && n < N + 5) begin
      @(negedge clock);
      n++;
    end
    chk("b2b_done_seen", 64'(done), 64'(1));
    chk("b2b_state_done", 64'(state_o), 64'(2));
    issue(2'b01, XLEN'(32'h8000_0001), XLEN'(32'h7FFF_FFFF), TAG_W'(7), 1'b1);
    drain(N + 5);

    // Squash during the 4th iteration
    issue(2'b00, XLEN'(11), XLEN'(13), TAG_W'(8), 1'b0);
    repeat (4) @(negedge clock);
    squash = 1'b1;
    #1;
    chk("ready_while_squash", 64'(ready), 64'(0));
    @(negedge clock);
    squash = 1'b0;
    #1;
    chk("ready_after_squash", 64'(ready), 64'(1));
    chk("state_after_squash", 64'(state_o), 64'(0));
    d0 = done_cnt;
    repeat (N + 3) @(negedge clock);
    chk("no_done_after_squash", 64'(done_cnt), 64'(d0));
    chk("product_hold", 64'(product), 64'(last_prod));
    chk("tag_hold", 64'(tag_out), 64'(last_tag));

    // Squash coincident with start: start dropped
    squash = 1'b1;
    start  = 1'b1;
    func   = 2'b00;
    mcand  = XLEN'(3);
    mplier = XLEN'(3);
    tag_in = TAG_W'(9);
    #1;
    chk("ready_with_squash", 64'(ready), 64'(0));
    @(posedge clock);
    #1;
    start  = 1'b0;
    squash = 1'b0;
    chk("state_start_squashed", 64'(state_o), 64'(0));
    d0 = done_cnt;
    repeat (N + 3) @(negedge clock);
    chk("no_done_start_squashed", 64'(done_cnt), 64'(d0));

    // Zero operand (latency depends on the bypass option)
    issue(2'b00, XLEN'(0), XLEN'(257), TAG_W'(10), 1'b1);    drain(N + 5);
    chk("zero_product", 64'(product), 64'(0));

    // Reset asserted mid-operation at iteration 3
    issue(2'b00, XLEN'(6), XLEN'(7), TAG_W'(12), 1'b1);      drain(N + 5);
    issue(2'b00, XLEN'(3), XLEN'(5), TAG_W'(13), 1'b0);
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_product", 64'(product), 64'(0));
    chk("midrst_tag_out", 64'(tag_out), 64'(0));
    chk("midrst_state", 64'(state_o), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("midrst_ready", 64'(ready), 64'(1));
    d0 = done_cnt;
    repeat (N + 3) @(negedge clock);
    chk("midrst_no_done", 64'(done_cnt), 64'(d0));

    // Random operations
    for (int i = 0; i < 200; i++) begin
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      a = XLEN'({$urandom(), $urandom()});
      b = XLEN'({$urandom(), $urandom()});
      if ($urandom_range(0, 15) == 0) a = '0;
      if ($urandom_range(0, 15) == 0) b = '1;
      issue(2'($urandom_range(0, 3)), a, b, TAG_W'($urandom()), 1'b1);
      drain(N + 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
